// File: rtl/snake_pkg.sv
// Shared types, grid constants and pixel helper for the snake motion block.
package snake_pkg;

   localparam int unsigned GRID_W  = 32;
   localparam int unsigned GRID_H  = 24;
   localparam int unsigned CELL_PX = 20;
   localparam int unsigned START_X = 16;
   localparam int unsigned START_Y = 12;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic {ST_RUN, ST_DEAD} state_t;

   typedef logic [4:0] cell_t;

   // Cell index to pixel coordinate; 31*20 = 620 fits in 10 bits.
   function automatic logic [9:0] cell_to_px(input cell_t c);
      return 10'(c) * 10'(CELL_PX);
   endfunction

   function automatic logic is_opposite(input dir_t a, input dir_t b);
      return (a == DIR_UP    && b == DIR_DOWN)  ||
             (a == DIR_DOWN  && b == DIR_UP)    ||
             (a == DIR_LEFT  && b == DIR_RIGHT) ||
             (a == DIR_RIGHT && b == DIR_LEFT);
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step timer: counts 0..TICK_DIV-1 and flags the terminal count as the step cycle.
module snake_tick_gen #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;

   // Free-running counter that wraps on the step cycle.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

   assign tick = (count == CW'(TICK_DIV - 1));

endmodule

// File: rtl/snake_motion.sv
// Snake head/body motion on a 32x24 grid with self-collision detection.
// Optional feature: define SNAKE_WALL_KILL_EN to make leaving the grid fatal
// instead of wrapping to the opposite edge.
module snake_motion
   import snake_pkg::*;
#(
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned MAX_LEN  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] dir_req,
   input  logic [7:0] score,
   output logic [9:0] newposx,
   output logic [9:0] newposy,
   output logic       move_tick,
   output logic       game_over,
   input  logic [5:0] seg_idx,
   output logic [9:0] seg_x,
   output logic [9:0] seg_y,
   output logic       seg_valid
);

   typedef logic [6:0] len_t;

   logic   step;
   state_t state, state_next;
   dir_t   dir, pending_dir, req_dir, ref_dir;
   logic   req_any;
   cell_t  seg_cx [MAX_LEN];
   cell_t  seg_cy [MAX_LEN];
   len_t   len, len_next;
   cell_t  head_x, head_y;
   logic   off_grid, hit_body, collide, advance;

   snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (step)
   );

   // Resolve a multi-bit request by priority up > down > left > right.
   always_comb begin
      req_any = |dir_req;
      req_dir = DIR_RIGHT;
      if (dir_req[3])
         req_dir = DIR_UP;
      else if (dir_req[2])
         req_dir = DIR_DOWN;
      else if (dir_req[1])
         req_dir = DIR_LEFT;
   end

   // Next head cell in the pending direction, wrapping at the grid edges.
   always_comb begin
      head_x   = seg_cx[0];
      head_y   = seg_cy[0];
      off_grid = 1'b0;
      case (pending_dir)
         DIR_UP: begin
            off_grid = (seg_cy[0] == '0);
            head_y   = off_grid ? cell_t'(GRID_H - 1) : seg_cy[0] - 5'd1;
         end
         DIR_DOWN: begin
            off_grid = (seg_cy[0] == cell_t'(GRID_H - 1));
            head_y   = off_grid ? '0 : seg_cy[0] + 5'd1;
         end
         DIR_LEFT: begin
            off_grid = (seg_cx[0] == '0);
            head_x   = off_grid ? cell_t'(GRID_W - 1) : seg_cx[0] - 5'd1;
         end
         DIR_RIGHT: begin
            off_grid = (seg_cx[0] == cell_t'(GRID_W - 1));
            head_x   = off_grid ? '0 : seg_cx[0] + 5'd1;
         end
      endcase
   end

   // Length for this step: score clamped to [1, MAX_LEN].
   always_comb begin
      if (score == '0)
         len_next = len_t'(1);
      else if (score > 8'(MAX_LEN))
         len_next = len_t'(MAX_LEN);
      else
         len_next = len_t'(score);
   end

   // Body hit against old segments 1..len-2; the vacating tail cell is excluded.
   always_comb begin
      hit_body = 1'b0;
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
         if ((len_t'(i) + len_t'(1) < len_next) &&
             (seg_cx[i] == head_x) && (seg_cy[i] == head_y))
            hit_body = 1'b1;
      end
   end

`ifdef SNAKE_WALL_KILL_EN
   assign collide = hit_body | off_grid;
`else
   assign collide = hit_body;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_RUN;
      else
         state <= state_next;
   end

   // Next state and step qualification.
   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         ST_RUN: begin
            if (step) begin
               if (collide)
                  state_next = ST_DEAD;
               else
                  advance = 1'b1;
            end
         end
         ST_DEAD: state_next = ST_DEAD;
      endcase
   end

   assign game_over = (state == ST_DEAD);

   // A request in the step cycle is judged against the direction being adopted.
   assign ref_dir = advance ? pending_dir : dir;

   // Current and pending direction registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         dir         <= DIR_RIGHT;
         pending_dir <= DIR_RIGHT;
      end else begin
         if (advance)
            dir <= pending_dir;
         if (req_any && !is_opposite(req_dir, ref_dir))
            pending_dir <= req_dir;
      end
   end

   // Body shift, length capture and registered head outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_cx[i] <= cell_t'(START_X);
            seg_cy[i] <= cell_t'(START_Y);
         end
         len       <= len_t'(1);
         newposx   <= cell_to_px(cell_t'(START_X));
         newposy   <= cell_to_px(cell_t'(START_Y));
         move_tick <= 1'b0;
      end else begin
         move_tick <= advance;
         if (advance) begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
               seg_cx[i] <= seg_cx[i-1];
               seg_cy[i] <= seg_cy[i-1];
            end
            seg_cx[0] <= head_x;
            seg_cy[0] <= head_y;
            len       <= len_next;
            newposx   <= cell_to_px(head_x);
            newposy   <= cell_to_px(head_y);
         end
      end
   end

   // Registered segment read port; out-of-range indices return zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_x     <= '0;
         seg_y     <= '0;
         seg_valid <= 1'b0;
      end else begin
         seg_x     <= '0;
         seg_y     <= '0;
         seg_valid <= 1'b0;
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (seg_idx == 6'(i)) begin
               seg_x     <= cell_to_px(seg_cx[i]);
               seg_y     <= cell_to_px(seg_cy[i]);
               seg_valid <= (len_t'(i) < len);
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_motion.sv
// Scoreboard bench for snake_motion: a queue-based snake model predicts each
// step's head position or death; a monitor pops on move_tick / game_over rise.
module tb_snake_motion;

   localparam int TD = 4;
   localparam int ML = 8;
   localparam int UP = 0, DN = 1, LT = 2, RT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] dir_req = '0;
   logic [7:0] score = 8'd1;
   logic [5:0] seg_idx = '0;
   logic [9:0] newposx, newposy, seg_x, seg_y;
   logic       move_tick, game_over, seg_valid;

   snake_motion #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (
      .clk       (clk),
      .reset     (reset),
      .dir_req   (dir_req),
      .score     (score),
      .newposx   (newposx),
      .newposy   (newposy),
      .move_tick (move_tick),
      .game_over (game_over),
      .seg_idx   (seg_idx),
      .seg_x     (seg_x),
      .seg_y     (seg_y),
      .seg_valid (seg_valid)
   );

   always #5 clk = ~clk;

   typedef struct { bit dead; int x; int y; } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Model: snake as a queue of cells, head at index 0.
   int bx[$], by[$];
   int m_len, m_dir, m_pend;
   bit m_dead;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void m_reset();
      bx.delete();
      by.delete();
      for (int i = 0; i < ML; i++) begin
         bx.push_back(16);
         by.push_back(12);
      end
      m_len  = 1;
      m_dir  = RT;
      m_pend = RT;
      m_dead = 1'b0;
   endfunction

   function automatic void m_request(input logic [3:0] r);
      int d;
      if (r == 4'd0) return;
      d = r[3] ? UP : (r[2] ? DN : (r[1] ? LT : RT));
      if (!((d == UP && m_dir == DN) || (d == DN && m_dir == UP) ||
            (d == LT && m_dir == RT) || (d == RT && m_dir == LT)))
         m_pend = d;
   endfunction

   // Advance the model by one step; returns 1 when the head moved.
   function automatic bit m_step(input int sc);
      int nx, ny, nl;
      bit hit;
      if (m_dead) return 1'b0;
      m_dir = m_pend;
      nx = bx[0];
      ny = by[0];
      if (m_dir == RT) nx++;
      if (m_dir == LT) nx--;
      if (m_dir == DN) ny++;
      if (m_dir == UP) ny--;
      hit = 1'b0;
`ifdef SNAKE_WALL_KILL_EN
      if (nx < 0 || nx > 31 || ny < 0 || ny > 23) hit = 1'b1;
`endif
      nx = (nx + 32) % 32;
      ny = (ny + 24) % 24;
      nl = (sc < 1) ? 1 : ((sc > ML) ? ML : sc);
      // After the move the body is {new, old[0..nl-2]}: new head must not be there.
      for (int k = 0; k < nl - 1; k++)
         if (bx[k] == nx && by[k] == ny) hit = 1'b1;
      if (hit) begin
         m_dead = 1'b1;
         sb.push_back('{dead: 1'b1, x: bx[0] * 20, y: by[0] * 20});
         return 1'b0;
      end
      bx.push_front(nx);
      by.push_front(ny);
      void'(bx.pop_back());
      void'(by.pop_back());
      m_len = nl;
      sb.push_back('{dead: 1'b0, x: nx * 20, y: ny * 20});
      return 1'b1;
   endfunction

   task automatic do_reset();
      reset   = 1'b1;
      dir_req = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      check("rst_newposx", newposx, 320);
      check("rst_newposy", newposy, 240);
      check("rst_move_tick", move_tick, 0);
      check("rst_game_over", game_over, 0);
      check("rst_seg_valid", seg_valid, 0);
      check("rst_seg_x", seg_x, 0);
   endtask

   // One full step window of TD cycles starting just after the timer wrapped.
   task automatic do_step(input logic [3:0] req, input int sc, input int ridx);
      int idx, ex_x, ex_y, ex_v;
      bit moved;
      idx = (ridx < 0) ? int'($urandom_range(0, ML + 1)) : ridx;
      if (idx < ML) begin
         ex_x = bx[idx] * 20;
         ex_y = by[idx] * 20;
         ex_v = (idx < m_len) ? 1 : 0;
      end else begin
         ex_x = 0;
         ex_y = 0;
         ex_v = 0;
      end
      seg_idx = 6'(idx);
      dir_req = req;
      score   = 8'(sc);
      m_request(req);
      moved = m_step(sc);
      @(posedge clk);
      @(negedge clk);
      dir_req = '0;
      check("seg_x", seg_x, ex_x);
      check("seg_y", seg_y, ex_y);
      check("seg_valid", seg_valid, ex_v);
      repeat (TD - 1) @(posedge clk);
      @(negedge clk);
      check("move_tick", move_tick, moved);
      check("game_over", game_over, m_dead);
      check("head_x", newposx, bx[0] * 20);
      check("head_y", newposy, by[0] * 20);
   endtask

   // Monitor: every head update or death must match the next scoreboard entry.
   logic prev_go = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (move_tick === 1'b1 || (game_over === 1'b1 && prev_go == 1'b0)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: move_tick=%0b game_over=%0b with no expected event at %0t",
                     move_tick, game_over, $time);
         end else begin
            e = sb.pop_front();
            check("sb_kind", int'(game_over), int'(e.dead));
            check("sb_x", newposx, e.x);
            check("sb_y", newposy, e.y);
         end
      end
      prev_go <= (game_over === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rq;
      int sc;

      // Straight run, reversal rejection, priority.
      do_reset();
      repeat (3) do_step(4'b0000, 1, -1);
      check("straight_x", newposx, 380);
      do_step(4'b0010, 1, -1);
      check("reverse_ignored_x", newposx, 400);
      do_step(4'b1000, 1, -1);
      check("turn_up_y", newposy, 220);
      do_step(4'b1010, 1, -1);
      check("up_wins_y", newposy, 200);
      check("up_wins_x", newposx, 400);

      // Right edge.
      do_reset();
      repeat (15) do_step(4'b0000, 1, -1);
      check("edge_x31", newposx, 620);
      do_step(4'b0000, 1, -1);
`ifdef SNAKE_WALL_KILL_EN
      check("wall_kill_go", game_over, 1);
      check("wall_kill_x", newposx, 620);
`else
      check("wrap_x", newposx, 0);
`endif

      // Closing a loop into the body with length 5.
      do_reset();
      do_step(4'b0001, 5, -1);
      do_step(4'b0100, 5, -1);
      do_step(4'b0010, 5, -1);
      do_step(4'b1000, 5, -1);
      check("self_hit_go", game_over, 1);
      repeat (2) do_step(4'b0001, 5, -1);
      check("frozen_x", newposx, 320);
      check("frozen_y", newposy, 260);

      // One-cycle reset out of DEAD, then read-port validity with length 2.
      do_reset();
      do_step(4'b0000, 2, -1);
      do_step(4'b0000, 2, 3);
      do_step(4'b0000, 2, 1);

      // Length 4 chasing its own tail around a 2x2 square.
      do_reset();
      repeat (2) begin
         do_step(4'b0001, 4, -1);
         do_step(4'b0100, 4, -1);
         do_step(4'b0010, 4, -1);
         do_step(4'b1000, 4, -1);
      end
      check("tail_chase_go", game_over, 0);

      // Random play.
      do_reset();
      sc = 3;
      for (int n = 0; n < 300; n++) begin
         if (m_dead && $urandom_range(0, 2) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 4) == 0) sc = int'($urandom_range(0, 10));
            rq = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            do_step(rq, sc, -1);
         end
      end

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snake_motion.md
SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 Parameter: TICK_DIV, 25_000_000, clk cycles per snake step (must be >= 2).
REQ-002 Parameter: MAX_LEN, 32, body buffer depth in segments (2..64).
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: dir_req  in  4  one-hot {up, down, left, right}; level-sampled every cycle.
REQ-006 Port: score  in  8  current score from the apple logic; sets snake length.
REQ-007 Port: newposx  out  10  head x in pixels, always CELL_PX * cell_x.
REQ-008 Port: newposy  out  10  head y in pixels, always CELL_PX * cell_y.
REQ-009 Port: move_tick  out  1  one-cycle pulse in the cycle the head position updates.
REQ-010 Port: game_over  out  1  high while in state DEAD.
REQ-011 Port: seg_idx  in  6  body segment read index; 0 is the head.
REQ-012 Port: seg_x, seg_y  out  10 each  pixel position of segment seg_idx.
REQ-013 Port: seg_valid  out  1  high when seg_idx < current length.

Function
REQ-014 The grid SHALL be 32 x 24 cells of 20 px; cell_x is 0..31 and cell_y is 0..23.
REQ-015 The step timer SHALL count 0..TICK_DIV-1 and wrap; the terminal count is the step cycle.
REQ-016 The direction register SHALL hold UP, DOWN, LEFT or RIGHT.
REQ-017 Direction requests:
- Any cycle, a request SHALL update pending_dir.
- Multi-bit requests SHALL resolve by priority up > down > left > right.
- A request exactly opposite to the current direction SHALL be ignored.
- pending_dir SHALL become the current direction at the next step.
REQ-018 States SHALL be RUN and DEAD. RUN goes to DEAD on collision. DEAD is left only by reset.
REQ-019 On each step in RUN, the next head SHALL be the current head moved one cell in the current direction.
REQ-020 Edge wrap: x 31 to 0 and 0 to 31; y 23 to 0 and 0 to 23.
REQ-021 Length SHALL be score clamped to [1, MAX_LEN], sampled on the step cycle only.
REQ-022 On a step, the body buffer SHALL shift: seg[i] <= seg[i-1], then seg[0] <= next head.
REQ-023 Self-collision:
- It occurs when the next head equals seg[i] for any 0 < i < len-1 (old contents).
- The vacating tail cell SHALL NOT count as a collision.
REQ-024 On collision:
- The state SHALL go to DEAD.
- The buffer and the head SHALL NOT update.
- move_tick SHALL NOT pulse.
REQ-025 In DEAD, all positions SHALL be frozen, game_over=1, and no move_tick.
REQ-026 newposx, newposy and move_tick SHALL be registered and SHALL change in the same cycle, one clock after the step cycle.
REQ-027 Read port: seg_x, seg_y and seg_valid SHALL be registered with 1-cycle latency from seg_idx.
REQ-028 For seg_idx >= MAX_LEN, the read port SHALL return 0,0 with seg_valid=0.
REQ-029 Pixel conversion SHALL be cell*20, computed in 10 bits without overflow (max 620/460).

Reset
REQ-030 While reset=1, on each clk edge:
- timer=0, state=RUN, direction=pending_dir=RIGHT.
- every seg = cell (16,12); newposx=320, newposy=240.
- move_tick=0, game_over=0, seg_x=seg_y=0, seg_valid=0.
REQ-031 Reset asserted mid-step or in DEAD SHALL take priority over all other updates.

Configuration
REQ-032 Macro SNAKE_WALL_KILL_EN:
- When defined, a next head outside the grid SHALL be a collision (REQ-024), replacing wrap.
- When undefined, REQ-020 wrap applies.

Structure
REQ-033 Package snake_pkg SHALL hold:
- direction enum;
- GRID_W=32, GRID_H=24, CELL_PX=20;
- START_X=16, START_Y=12;
- state enum.
REQ-034 The step timer SHALL be a sub-module snake_tick_gen (param TICK_DIV; ports clk, reset, tick).

Verification (TICK_DIV=4, MAX_LEN=8)
REQ-035 Reset, then no input for 3 steps -> newposx 340, 360, 380; newposy=240; move_tick pulses every 4 cycles.
REQ-036 Heading RIGHT, dir_req=left -> ignored. Then up -> next step newposy=220. Then up+left together -> up wins.
REQ-037 Head at x=31 moving right -> next newposx=0 (macro undefined); with SNAKE_WALL_KILL_EN defined -> game_over=1 and newposx stays 620.
REQ-038 score=5, path right, down, left, up into the body -> game_over=1 on the closing step, positions frozen thereafter.
REQ-039 score=4, 2x2 loop where the head enters the just-vacated tail cell -> no game_over.
REQ-040 In DEAD, assert reset for 1 cycle -> game_over=0 and newposx/newposy=320/240 on the next cycle; seg_idx=3 with len 2 -> seg_valid=0.
